// File: rtl/sr_ff_checker.sv
// Observer and reference model for a clocked SR flip-flop.
// Predicts Q one cycle behind S/R and counts checks and mismatches.
module sr_ff_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             S,
    input  logic             R,
    input  logic             Q,
    input  logic             Qn,
    output logic             EXP_VALID,
    output logic             EXP_Q,
    output logic             MISMATCH,
    output logic             INVALID,
    output logic             ERR,
    output logic             HALTED,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [CNT_W-1:0] FIRST_ERR_AT
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_TRACK   = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic             exp_q;
    logic             exp_q_nx;
    logic             mism_r;
    logic             mism_nx;
    logic             inv_r;
    logic             inv_nx;
    logic             err_r;
    logic             err_nx;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] err_cnt_nx;
    logic [CNT_W-1:0] chk_cnt;
    logic [CNT_W-1:0] chk_cnt_nx;
    logic [CNT_W-1:0] first_err;
    logic [CNT_W-1:0] first_err_nx;

    logic active;
    logic checking;
    logic mism;

    // The check compares against the prediction made at the previous edge,
    // since the DUT output lags its S/R inputs by one cycle.
    assign active   = EN && (state != ST_HALT);
    assign checking = active && (state == ST_TRACK);
    assign mism     = checking && ((Q != exp_q) || (Qn != ~exp_q));

    always_comb begin
        state_nx     = state;
        exp_q_nx     = exp_q;
        mism_nx      = 1'b0;
        inv_nx       = 1'b0;
        err_nx       = err_r;
        err_cnt_nx   = err_cnt;
        chk_cnt_nx   = chk_cnt;
        first_err_nx = first_err;

        if (active) begin
            mism_nx = mism;
            inv_nx  = S & R;

            if (checking && (chk_cnt != CNT_MAX)) begin
                chk_cnt_nx = chk_cnt + CNT_ONE;
            end

            if (mism) begin
                err_nx = 1'b1;
                if (err_cnt != CNT_MAX) begin
                    err_cnt_nx = err_cnt + CNT_ONE;
                end
                if (!err_r) begin
                    first_err_nx = chk_cnt;
                end
            end

            if (STOP_ON_ERR && mism) begin
                state_nx = ST_HALT;
            end else begin
                unique case ({S, R})
                    2'b10: begin
                        exp_q_nx = 1'b1;
                        state_nx = ST_TRACK;
                    end
                    2'b01: begin
                        exp_q_nx = 1'b0;
                        state_nx = ST_TRACK;
                    end
                    2'b11: begin
                        exp_q_nx = 1'b0;
                        state_nx = ST_UNKNOWN;
                    end
                    default: begin
                        exp_q_nx = exp_q;
                        state_nx = state;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_UNKNOWN;
            exp_q     <= 1'b0;
            mism_r    <= 1'b0;
            inv_r     <= 1'b0;
            err_r     <= 1'b0;
            err_cnt   <= '0;
            chk_cnt   <= '0;
            first_err <= '0;
        end else begin
            state     <= state_nx;
            exp_q     <= exp_q_nx;
            mism_r    <= mism_nx;
            inv_r     <= inv_nx;
            err_r     <= err_nx;
            err_cnt   <= err_cnt_nx;
            chk_cnt   <= chk_cnt_nx;
            first_err <= first_err_nx;
        end
    end

    assign EXP_VALID    = (state == ST_TRACK);
    assign HALTED       = (state == ST_HALT);
    assign EXP_Q        = exp_q;
    assign MISMATCH     = mism_r;
    assign INVALID      = inv_r;
    assign ERR          = err_r;
    assign ERR_CNT      = err_cnt;
    assign CHK_CNT      = chk_cnt;
    assign FIRST_ERR_AT = first_err;

endmodule
